text_console_writer: RTL and testbench
======================================

Name: text_console_writer

Overview:
- Write-side engine for the text-mode VRAM. It consumes a byte stream, for example from a UART receiver, and interprets it as a terminal.
- It drives the write port (port A) of the semi-dual-port text RAM. The display pipeline reads the same RAM through port B.
- Each RAM word it writes is {attr[7:0], char[7:0]}. Attribute layout: bit 7 blink, bits 6:4 background, bits 3:0 foreground IRGB.
- Screen is 30 columns x 17 rows of 16x16-pixel cells. RAM address is {row[4:0], col[4:0]}.

Parameters:
- COLS, 30, visible columns per row; columns 30..31 are never written.
- ROWS, 17, visible rows.
- DEF_ATTR, 8'h07, attribute after reset (light grey on black, no blink).

Ports:
- clk_i  in  1  pixel/system clock; same clock as the RAM port A clock.
- rstn_i  in  1  asynchronous active-low reset.
- data_i  in  8  input byte.
- valid_i  in  1  data_i is valid.
- ready_o  out  1  block accepts a byte this cycle.
- wr_en_o  out  1  RAM port A write strobe; drives cea.
- wr_addr_o  out  10  RAM port A address, {row, col}.
- wr_data_o  out  16  RAM port A data, {attr, char}.
- cur_row_o  out  5  current cursor row.
- cur_col_o  out  5  current cursor column.
- busy_o  out  1  a clear operation is in progress.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; cursor (0,0); attr = DEF_ATTR.
  - wr_en_o=0, wr_addr_o=0, wr_data_o=0, busy_o=0.
  - ready_o=1 once reset releases.
- A reset asserted mid-clear aborts the clear immediately. RAM contents are left as partially written.
- Handshake:
  - A byte is accepted when valid_i & ready_o at a rising edge.
  - ready_o is 1 only in IDLE and ESC. It is combinational from state.
  - data_i may change freely when not accepted.
- All write-port outputs are registered. Each write is a single-cycle pulse on wr_en_o, asserted the cycle after acceptance.
- States: IDLE, ESC, CLR_SCREEN, CLR_LINE.
- IDLE, on an accepted byte b:
  - 0x20..0x7E (printable):
    - Write {attr, b} at (row, col), then advance col.
    - If col == COLS-1: col=0 and row advances (newline path).
  - 0x0D (CR): col=0; no write.
  - 0x0A (LF): row advances; col unchanged; no write.
  - 0x08 (BS): if col>0 then col-1; no write; at col 0 nothing happens.
  - 0x0C (FF): cursor=(0,0), go to CLR_SCREEN.
  - 0x1B (ESC): go to ESC.
  - Any other byte is accepted and ignored.
- ESC: the next accepted byte is loaded into attr, return to IDLE. No write.
- Row advance: row == ROWS-1 wraps to row 0. There is no scrolling.
- CLR_SCREEN:
  - Writes {attr, 8'h20} to every visible cell, row-major from (0,0) to (16,29): one write per cycle, 510 cycles.
  - ready_o=0 and busy_o=1 throughout.
  - The cycle after the last write: wr_en_o=0, busy_o=0, state IDLE.
  - The cursor outputs show (0,0) from the cycle after FF is accepted.
- CLR_LINE: used only with LINE_CLEAR_EN (see Optional Feature).
- Simultaneous events: a printable char at the last cell (16,29) writes at (16,29), then the cursor goes to (0,0).
- Simultaneous events: valid_i held high while busy is not consumed. The byte is accepted on the first cycle ready_o returns to 1.
- The cursor register update happens on the same edge as the write-register load. wr_addr_o always shows the pre-advance position.

Optional Feature:
- Macro: TEXT_CONSOLE_LINE_CLEAR_EN.
- Defined:
  - Every row advance (wrap from the last column, or LF) enters CLR_LINE.
  - CLR_LINE writes {attr, 8'h20} to columns 0..29 of the new row: 30 cycles, ready_o=0, busy_o=1.
  - It then returns to IDLE.
  - This gives clean terminal-style output after wrap-around.
- Not defined: a row advance only moves the cursor, old text remains, and CLR_LINE is not synthesised.

Test Plan:
- Reset, send 'A' (0x41) -> one cycle later: wr_en_o=1, wr_addr_o=10'h000, wr_data_o=16'h0741; cursor (0,1).
- Send ESC, 0x1E, 'B' -> ESC and 0x1E cause no write; 'B' writes 16'h1E42; attr is kept for later chars.
- Send 30 printable chars from (0,0) -> the last write is at addr {5'd0,5'd29}; cursor becomes (1,0). With the macro: 30 writes of 0x20 to row 1, busy_o=1 for 30 cycles.
- From cursor (16,5), send LF -> cursor (0,5); no write (macro off).
- Send FF with valid_i held high and a following 'C' -> exactly 510 space writes; addresses skip columns 30/31; ready_o=0 throughout; 'C' then written at (0,0).
- Assert rstn_i low at cycle 100 of CLR_SCREEN -> wr_en_o=0 immediately (async); after release: cursor (0,0), attr 8'h07, ready_o=1.
- Edge cases: BS at col 0 leaves the cursor at col 0 with no write; BS at col 3 gives col 2.

Source files
------------

// File: rtl/text_console_writer.sv
// Terminal-style byte interpreter driving the write port of the 30x17 text VRAM.
// Optional per-row clearing on row advance is enabled by TEXT_CONSOLE_LINE_CLEAR_EN.
module text_console_writer #(
    parameter int unsigned COLS     = 30,
    parameter int unsigned ROWS     = 17,
    parameter logic [7:0]  DEF_ATTR = 8'h07
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [7:0]  data_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic        wr_en_o,
    output logic [9:0]  wr_addr_o,
    output logic [15:0] wr_data_o,
    output logic [4:0]  cur_row_o,
    output logic [4:0]  cur_col_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {IDLE, ESC, CLR_SCREEN, CLR_LINE} state_t;

    localparam logic [4:0] LAST_COL = 5'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
    localparam logic [7:0] SPACE    = 8'h20;

    state_t      state_q, state_d;
    logic [4:0]  row_q, row_d, col_q, col_d;
    logic [4:0]  clr_row_q, clr_row_d, clr_col_q, clr_col_d;
    logic        clr_last_q, clr_last_d;
    logic [7:0]  attr_q, attr_d;
    logic        wr_en_q, wr_en_d;
    logic [9:0]  wr_addr_q, wr_addr_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic        accept;
    logic        advance;

    assign ready_o   = (state_q == IDLE) || (state_q == ESC);
    assign busy_o    = (state_q == CLR_SCREEN) || (state_q == CLR_LINE);
    assign accept    = valid_i & ready_o;
    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
    assign cur_row_o = row_q;
    assign cur_col_o = col_q;

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        clr_row_d  = clr_row_q;
        clr_col_d  = clr_col_q;
        clr_last_d = clr_last_q;
        attr_d     = attr_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        advance    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (data_i >= 8'h20 && data_i <= 8'h7E) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = {row_q, col_q};
                        wr_data_d = {attr_q, data_i};
                        if (col_q == LAST_COL) begin
                            col_d   = 5'd0;
                            advance = 1'b1;
                        end else begin
                            col_d = col_q + 5'd1;
                        end
                    end else begin
                        case (data_i)
                            8'h0D: col_d = 5'd0;
                            8'h0A: advance = 1'b1;
                            8'h08: if (col_q != 5'd0) col_d = col_q - 5'd1;
                            8'h0C: begin
                                // First cell is written on the accepting edge so busy_o
                                // covers exactly the 510 write pulses.
                                row_d      = 5'd0;
                                col_d      = 5'd0;
                                state_d    = CLR_SCREEN;
                                wr_en_d    = 1'b1;
                                wr_addr_d  = 10'd0;
                                wr_data_d  = {attr_q, SPACE};
                                clr_row_d  = 5'd0;
                                clr_col_d  = 5'd1;
                                clr_last_d = 1'b0;
                            end
                            8'h1B: state_d = ESC;
                            default: ;
                        endcase
                    end
                end
            end
            ESC: begin
                if (accept) begin
                    attr_d  = data_i;
                    state_d = IDLE;
                end
            end
            CLR_SCREEN: begin
                if (clr_last_q) begin
                    state_d = IDLE;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = {clr_row_q, clr_col_q};
                    wr_data_d = {attr_q, SPACE};
                    if (clr_col_q == LAST_COL) begin
                        clr_col_d = 5'd0;
                        if (clr_row_q == LAST_ROW) clr_last_d = 1'b1;
                        else                       clr_row_d  = clr_row_q + 5'd1;
                    end else begin
                        clr_col_d = clr_col_q + 5'd1;
                    end
                end
            end
            CLR_LINE: begin
`ifdef TEXT_CONSOLE_LINE_CLEAR_EN
                wr_en_d   = 1'b1;
                wr_addr_d = {row_q, clr_col_q};
                wr_data_d = {attr_q, SPACE};
                if (clr_col_q == LAST_COL) state_d   = IDLE;
                else                       clr_col_d = clr_col_q + 5'd1;
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase

        // Row advance wraps with no scrolling; row_q already holds the new row in CLR_LINE.
        if (advance) begin
            row_d = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;
`ifdef TEXT_CONSOLE_LINE_CLEAR_EN
            state_d   = CLR_LINE;
            clr_col_d = 5'd0;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            row_q      <= 5'd0;
            col_q      <= 5'd0;
            clr_row_q  <= 5'd0;
            clr_col_q  <= 5'd0;
            clr_last_q <= 1'b0;
            attr_q     <= DEF_ATTR;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= 10'd0;
            wr_data_q  <= 16'd0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            clr_row_q  <= clr_row_d;
            clr_col_q  <= clr_col_d;
            clr_last_q <= clr_last_d;
            attr_q     <= attr_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

endmodule

// File: tb/tb_text_console_writer.sv
// Bench for text_console_writer: cursor vector table plus a write scoreboard fed by a byte model.
module tb_text_console_writer;

    logic        clk = 1'b0;
    logic        rstn;
    logic [7:0]  data_i;
    logic        valid_i;
    logic        ready_o, wr_en_o, busy_o;
    logic [9:0]  wr_addr_o;
    logic [15:0] wr_data_o;
    logic [4:0]  cur_row_o, cur_col_o;

    int total = 0;
    int bad   = 0;

    logic [25:0] sbQ[$];
    logic [4:0]  mRow, mCol;
    logic [7:0]  mAttr;
    logic        mEsc;

    typedef struct {
        logic [7:0] b;
        logic [4:0] row;
        logic [4:0] col;
    } vec_t;
    vec_t vecs[$];

    text_console_writer dut (
        .clk_i    (clk),
        .rstn_i   (rstn),
        .data_i   (data_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .wr_en_o  (wr_en_o),
        .wr_addr_o(wr_addr_o),
        .wr_data_o(wr_data_o),
        .cur_row_o(cur_row_o),
        .cur_col_o(cur_col_o),
        .busy_o   (busy_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void pushWrite(input logic [4:0] r, input logic [4:0] c,
                                      input logic [7:0] a, input logic [7:0] ch);
        sbQ.push_back({r, c, a, ch});
    endfunction

    function automatic void modelAdvance();
        mRow = (mRow == 5'd16) ? 5'd0 : mRow + 5'd1;
`ifdef TEXT_CONSOLE_LINE_CLEAR_EN
        for (int c = 0; c < 30; c++) pushWrite(mRow, 5'(c), mAttr, 8'h20);
`endif
    endfunction

    function automatic void modelByte(input logic [7:0] b);
        if (mEsc) begin
            mAttr = b;
            mEsc  = 1'b0;
        end else if (b >= 8'h20 && b <= 8'h7E) begin
            pushWrite(mRow, mCol, mAttr, b);
            if (mCol == 5'd29) begin
                mCol = 5'd0;
                modelAdvance();
            end else begin
                mCol = mCol + 5'd1;
            end
        end else if (b == 8'h0D) begin
            mCol = 5'd0;
        end else if (b == 8'h0A) begin
            modelAdvance();
        end else if (b == 8'h08) begin
            if (mCol != 5'd0) mCol = mCol - 5'd1;
        end else if (b == 8'h0C) begin
            mRow = 5'd0;
            mCol = 5'd0;
            for (int r = 0; r < 17; r++)
                for (int c = 0; c < 30; c++) pushWrite(5'(r), 5'(c), mAttr, 8'h20);
        end else if (b == 8'h1B) begin
            mEsc = 1'b1;
        end
    endfunction

    // Drive one byte once ready_o is seen, then release valid after the accepting edge.
    task automatic applyStimulus(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (!ready_o && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checkOutput("ready_timeout", 32'(ready_o), 32'd1);
        end else begin
            data_i  = b;
            valid_i = 1'b1;
            modelByte(b);
            @(posedge clk);
            #1;
            valid_i = 1'b0;
            data_i  = 8'hA5;
        end
    endtask

    always @(negedge clk) begin
        if (wr_en_o) begin
            if (sbQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none",
                         wr_addr_o, wr_data_o);
            end else begin
                logic [25:0] exp;
                exp = sbQ.pop_front();
                checkOutput("wr_addr", 32'(wr_addr_o), 32'(exp[25:16]));
                checkOutput("wr_data", 32'(wr_data_o), 32'(exp[15:0]));
            end
        end
    end

    initial begin
        int busyCnt;
        int n;
        rstn    = 1'b0;
        valid_i = 1'b0;
        data_i  = 8'h00;
        mRow = 5'd0; mCol = 5'd0; mAttr = 8'h07; mEsc = 1'b0;

        vecs.push_back('{8'h41, 5'd0, 5'd1});
        vecs.push_back('{8'h1B, 5'd0, 5'd1});
        vecs.push_back('{8'h1E, 5'd0, 5'd1});
        vecs.push_back('{8'h42, 5'd0, 5'd2});
        vecs.push_back('{8'h08, 5'd0, 5'd1});
        vecs.push_back('{8'h08, 5'd0, 5'd0});
        vecs.push_back('{8'h08, 5'd0, 5'd0});
        vecs.push_back('{8'h78, 5'd0, 5'd1});
        vecs.push_back('{8'h0D, 5'd0, 5'd0});
        vecs.push_back('{8'h0A, 5'd1, 5'd0});
        vecs.push_back('{8'h00, 5'd1, 5'd0});
        vecs.push_back('{8'h7F, 5'd1, 5'd0});
        vecs.push_back('{8'h1F, 5'd1, 5'd0});
        vecs.push_back('{8'h7E, 5'd1, 5'd1});
        vecs.push_back('{8'h61, 5'd1, 5'd2});
        vecs.push_back('{8'h62, 5'd1, 5'd3});
        vecs.push_back('{8'h08, 5'd1, 5'd2});

        #12;
        checkOutput("rst_wr_en",   32'(wr_en_o),   32'd0);
        checkOutput("rst_wr_addr", 32'(wr_addr_o), 32'd0);
        checkOutput("rst_wr_data", 32'(wr_data_o), 32'd0);
        checkOutput("rst_busy",    32'(busy_o),    32'd0);
        checkOutput("rst_row",     32'(cur_row_o), 32'd0);
        checkOutput("rst_col",     32'(cur_col_o), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checkOutput("rst_ready", 32'(ready_o), 32'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].b);
            checkOutput($sformatf("vec%0d_row", i), 32'(cur_row_o), 32'(vecs[i].row));
            checkOutput($sformatf("vec%0d_col", i), 32'(cur_col_o), 32'(vecs[i].col));
        end

        // Return to (0,0) via CR and 16 LFs, then fill one full row.
        applyStimulus(8'h0D);
        for (int i = 0; i < 16; i++) applyStimulus(8'h0A);
        checkOutput("home_row", 32'(cur_row_o), 32'd0);
        for (int i = 0; i < 30; i++) applyStimulus(8'(8'h30 + (i % 10)));
        checkOutput("wrap_row", 32'(cur_row_o), 32'd1);
        checkOutput("wrap_col", 32'(cur_col_o), 32'd0);

        for (int i = 0; i < 15; i++) applyStimulus(8'h0A);
        for (int i = 0; i < 5; i++) applyStimulus(8'h4B);
        checkOutput("pre_lf_row", 32'(cur_row_o), 32'd16);
        checkOutput("pre_lf_col", 32'(cur_col_o), 32'd5);
        applyStimulus(8'h0A);
        checkOutput("lf_wrap_row", 32'(cur_row_o), 32'd0);
        checkOutput("lf_wrap_col", 32'(cur_col_o), 32'd5);

        applyStimulus(8'h0D);
        for (int i = 0; i < 16; i++) applyStimulus(8'h0A);
        for (int i = 0; i < 29; i++) applyStimulus(8'h2E);
        checkOutput("last_cell_col", 32'(cur_col_o), 32'd29);
        applyStimulus(8'h5A);
        checkOutput("last_wrap_row", 32'(cur_row_o), 32'd0);
        checkOutput("last_wrap_col", 32'(cur_col_o), 32'd0);

        // Form feed followed by a byte held valid across the whole clear.
        @(negedge clk);
        n = 0;
        while (!ready_o && n < 2000) begin
            @(negedge clk);
            n++;
        end
        data_i  = 8'h0C;
        valid_i = 1'b1;
        modelByte(8'h0C);
        @(posedge clk);
        #1;
        data_i = 8'h43;
        modelByte(8'h43);
        checkOutput("ff_cursor_row", 32'(cur_row_o), 32'd0);
        checkOutput("ff_cursor_col", 32'(cur_col_o), 32'd0);
        busyCnt = 0;
        n = 0;
        @(negedge clk);
        while (!ready_o && n < 2000) begin
            if (busy_o) busyCnt++;
            @(negedge clk);
            n++;
        end
        checkOutput("clr_busy_cycles", 32'(busyCnt), 32'd510);
        checkOutput("clr_end_busy",    32'(busy_o),  32'd0);
        checkOutput("clr_end_wr_en",   32'(wr_en_o), 32'd0);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        checkOutput("held_c_col", 32'(cur_col_o), 32'd1);

        // Reset asserted mid-clear must drop the write strobe at once.
        applyStimulus(8'h0C);
        repeat (100) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("abort_wr_en", 32'(wr_en_o), 32'd0);
        checkOutput("abort_busy",  32'(busy_o),  32'd0);
        sbQ.delete();
        mRow = 5'd0; mCol = 5'd0; mAttr = 8'h07; mEsc = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_rst_ready", 32'(ready_o),   32'd1);
        checkOutput("post_rst_row",   32'(cur_row_o), 32'd0);
        checkOutput("post_rst_col",   32'(cur_col_o), 32'd0);
        applyStimulus(8'h44);

        repeat (5) @(posedge clk);
        checkOutput("sb_empty", 32'(sbQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
